accumulator_ctrl: RTL and testbench
===================================

// Module: accumulator_ctrl
// PURPOSE
//  Sequences the column accumulator bank behind the systolic array for one output tile.
//  Clears the bank, then gates Cal on each valid partial-sum beat across num_tiles K-tiles.
//  Then drains SIZE column results through a valid/ready port and pulses done.
//  Sits between the top-level scheduler (start/done) and the accumulator bank.
// PARAMETERS
//  SIZE            8   array dimension = number of accumulator columns to drain
//  BEATS_PER_TILE  8   partial-sum beats (Cal cycles) per K-tile
//  TILE_CNT_W      8   width of num_tiles
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst_n       in   1           asynchronous reset, active-low
//  start       in   1           request new tile job; accepted only in IDLE
//  num_tiles   in   TILE_CNT_W  K-tiles to accumulate; sampled on accepted start; 0 => 1
//  ps_valid    in   1           partial-sum beat present on accumulator inputs
//  cal         out  1           accumulate enable to bank (Cal)
//  acc_clr     out  1           synchronous clear to bank
//  out_valid   out  1           drain word valid; column given by out_col
//  out_ready   in   1           downstream accepts drain word
//  out_col     out  $clog2(SIZE) column index being drained (mux select)
//  busy        out  1           high in every state except IDLE
//  done        out  1           one-cycle pulse after last column accepted
// BEHAVIOUR
//  Reset: state=IDLE; cal, acc_clr, out_valid, busy, done = 0; out_col=0; counters=0.
//  States: IDLE -> CLEAR -> ACCUM -> DRAIN -> DONE -> IDLE.
//  IDLE : start=1 latches max(num_tiles,1) into tiles_left, beat_cnt=0; next CLEAR.
//  CLEAR: acc_clr=1 exactly one cycle; next ACCUM. ps_valid here is ignored (cal=0).
//  ACCUM: cal = ps_valid (combinational, zero latency, same cycle as data).
//    beat_cnt++ per ps_valid; at beat_cnt==BEATS_PER_TILE-1 with ps_valid: beat_cnt=0, tiles_left--.
//    Beat that completes the last tile -> DRAIN next cycle; total Cal pulses = tiles*BEATS_PER_TILE.
//  DRAIN: out_valid=1, out_col=drain index from 0. Advance on out_valid&out_ready.
//    out_ready low: out_valid and out_col hold stable (no drop, no skip).
//    Accept of col SIZE-1 -> DONE; out_valid falls next cycle.
//  DONE : done=1 one cycle, busy=1; next IDLE (busy=0). start in DONE ignored.
//  Latency: start to first cal opportunity = 2 cycles; last accept to done = 1 cycle.
//  start while busy: ignored, latched job unaffected. ps_valid outside ACCUM: cal=0, no count.
//  cal and acc_clr never high in the same cycle; cal never high outside ACCUM.
//  rst_n low at any point: immediate return to reset values; partial job discarded.
//  Counters never wrap: tiles_left stops at 0, out_col stops at SIZE-1 by construction.
// CONFIGURATION
//  ACC_CTRL_ERR_EN defined: extra port err (out,1), sticky, reset 0.
//    Set by ps_valid in IDLE/CLEAR/DRAIN/DONE, or start while busy.
//    Cleared when a start is accepted in IDLE (same edge; a same-cycle error event wins).
//  Not defined: no err port; those events silently ignored as above.
// TESTING
//  T1 start, num_tiles=2, ps_valid held 1 -> acc_clr 1 cycle, cal high exactly 16 cycles, then DRAIN.
//  T2 num_tiles=0, ps_valid toggled 1/0 -> treated as 1 tile: 8 cal pulses only on ps_valid=1 cycles.
//  T3 DRAIN with out_ready low 3 cycles at col 2 -> out_col stays 2, out_valid 1; cols 0..7 each once, done 1 cycle.
//  T4 start pulsed during ACCUM and DRAIN -> no effect on counts; err=1 with ACC_CTRL_ERR_EN, cleared by next job.
//  T5 rst_n low mid-ACCUM after 5 beats -> all outputs 0 async; new start gives full clear and 8*num_tiles cals.
//  T6 ps_valid=1 during CLEAR and DRAIN -> cal stays 0; beat count unchanged.

Source files
------------

// File: rtl/accumulator_ctrl.sv
// -----------------------------------------------------------------------------
// accumulator_ctrl
//
// Sequences the column accumulator bank behind the systolic array for one
// output tile: clears the bank, gates Cal on every valid partial-sum beat
// across num_tiles K-tiles, drains SIZE column results through a valid/ready
// port and finally pulses done back to the scheduler.
//
// Optional feature: define ACC_CTRL_ERR_EN to add a sticky protocol-error
// output (err). Without it, the same events are silently ignored.
//
// Ports
//   clk        in   1             clock, all state on rising edge
//   rst_n      in   1             asynchronous reset, active-low
//   start      in   1             request new tile job (accepted only in IDLE)
//   num_tiles  in   TILE_CNT_W    K-tiles to accumulate (0 treated as 1)
//   ps_valid   in   1             partial-sum beat present on bank inputs
//   cal        out  1             accumulate enable to bank
//   acc_clr    out  1             synchronous clear to bank
//   out_valid  out  1             drain word valid (column = out_col)
//   out_ready  in   1             downstream accepts drain word
//   out_col    out  $clog2(SIZE)  column index being drained
//   busy       out  1             high in every state except IDLE
//   done       out  1             one-cycle pulse after last column accepted
//   err        out  1             sticky protocol error (ACC_CTRL_ERR_EN only)
// -----------------------------------------------------------------------------
module accumulator_ctrl #(
  parameter  int SIZE           = 8,
  parameter  int BEATS_PER_TILE = 8,
  parameter  int TILE_CNT_W     = 8,
  localparam int COL_W          = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TILE_CNT_W-1:0] num_tiles,
  input  logic                  ps_valid,
  output logic                  cal,
  output logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COL_W-1:0]      out_col,
  output logic                  busy,
  output logic                  done
`ifdef ACC_CTRL_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int BEAT_W = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_TILE - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [TILE_CNT_W-1:0]   tiles_left_q, tiles_left_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [COL_W-1:0]        col_q, col_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tiles_left_q <= '0;
      beat_cnt_q   <= '0;
      col_q        <= '0;
    end else begin
      state_q      <= state_d;
      tiles_left_q <= tiles_left_d;
      beat_cnt_q   <= beat_cnt_d;
      col_q        <= col_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    tiles_left_d = tiles_left_q;
    beat_cnt_d   = beat_cnt_q;
    col_d        = col_q;
    cal          = 1'b0;
    acc_clr      = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          tiles_left_d = (num_tiles == '0) ? TILE_CNT_W'(1) : num_tiles;
          beat_cnt_d   = '0;
          col_d        = '0;
          state_d      = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        acc_clr = 1'b1;
        state_d = ST_ACCUM;
      end

      ST_ACCUM: begin
        // Cal follows the beat in the same cycle as the data on the bank inputs.
        cal = ps_valid;
        if (ps_valid) begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d   = '0;
            tiles_left_d = tiles_left_q - TILE_CNT_W'(1);
            // tiles_left is at least 1 here, so it bottoms out at 0, never wraps.
            if (tiles_left_q == TILE_CNT_W'(1)) state_d = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        // out_valid/out_col hold while stalled: column only moves on a handshake.
        out_valid = 1'b1;
        if (out_ready) begin
          if (col_q == COL_LAST) state_d = ST_DONE;
          else                   col_d   = col_q + COL_W'(1);
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        col_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign out_col = col_q;

`ifdef ACC_CTRL_ERR_EN
  logic err_q, err_d, err_event;

  // A beat outside ACCUM or a start while busy is a protocol error. An
  // accepted start clears the flag unless an error event lands on that edge.
  always_comb begin
    err_event = (ps_valid && (state_q != ST_ACCUM)) ||
                (start    && (state_q != ST_IDLE));
    if (err_event)                           err_d = 1'b1;
    else if ((state_q == ST_IDLE) && start)  err_d = 1'b0;
    else                                     err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_accumulator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_accumulator_ctrl
//
// Self-checking bench for accumulator_ctrl. A behavioural model tracks the job
// as "total beats still owed" and "next column to hand out", derived from the
// job parameters with plain arithmetic; a job-level scoreboard counts the Cal
// pulses and drained columns actually seen and compares them at done.
// Define ACC_CTRL_ERR_EN to also check the sticky err output.
// -----------------------------------------------------------------------------
module tb_accumulator_ctrl;

  localparam int SIZE   = 8;
  localparam int BEATS  = 8;
  localparam int TW     = 8;
  localparam int CW     = 3;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_ACCUM = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic          ps_valid;
  logic          cal;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;
`ifdef ACC_CTRL_ERR_EN
  logic          err;
`endif

  accumulator_ctrl #(
    .SIZE          (SIZE),
    .BEATS_PER_TILE(BEATS),
    .TILE_CNT_W    (TW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_tiles(num_tiles),
    .ps_valid (ps_valid),
    .cal      (cal),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_col  (out_col),
    .busy     (busy),
    .done     (done)
`ifdef ACC_CTRL_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  int m_phase      = P_IDLE;
  int m_beats_left = 0;
  int m_col        = 0;
  bit m_err        = 1'b0;

  // Job-level scoreboard fed from DUT observations.
  int job_tiles    = 0;
  int dut_cal_cnt  = 0;
  int next_col     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input bit s, input logic [TW-1:0] nt, input bit psv, input bit rdy);
    bit ev;
    @(negedge clk);
    start     = s;
    num_tiles = nt;
    ps_valid  = psv;
    out_ready = rdy;
    #1;
    check("cal",       32'(cal),       32'((m_phase == P_ACCUM) && psv));
    check("acc_clr",   32'(acc_clr),   32'(m_phase == P_CLEAR));
    check("out_valid", 32'(out_valid), 32'(m_phase == P_DRAIN));
    check("out_col",   32'(out_col),   32'(m_col));
    check("busy",      32'(busy),      32'(m_phase != P_IDLE));
    check("done",      32'(done),      32'(m_phase == P_DONE));
`ifdef ACC_CTRL_ERR_EN
    check("err",       32'(err),       32'(m_err));
`endif

    if (cal === 1'b1) dut_cal_cnt++;
    if ((out_valid === 1'b1) && rdy) begin
      check("drain_col_order", 32'(out_col), 32'(next_col));
      next_col++;
    end
    if (m_phase == P_DONE) begin
      check("job_cal_total", 32'(dut_cal_cnt), 32'(job_tiles * BEATS));
      check("job_cols",      32'(next_col),    32'(SIZE));
    end

    ev = (psv && (m_phase != P_ACCUM)) || (s && (m_phase != P_IDLE));
    case (m_phase)
      P_IDLE: begin
        if (s) begin
          job_tiles    = (nt == 0) ? 1 : int'(nt);
          m_beats_left = job_tiles * BEATS;
          m_col        = 0;
          m_phase      = P_CLEAR;
          m_err        = ev;
          dut_cal_cnt  = 0;
          next_col     = 0;
        end else begin
          m_err = m_err | ev;
        end
      end
      P_CLEAR: begin
        m_phase = P_ACCUM;
        m_err   = m_err | ev;
      end
      P_ACCUM: begin
        if (psv) begin
          m_beats_left--;
          if (m_beats_left == 0) m_phase = P_DRAIN;
        end
        m_err = m_err | ev;
      end
      P_DRAIN: begin
        if (rdy) begin
          if (m_col == SIZE - 1) m_phase = P_DONE;
          else                   m_col++;
        end
        m_err = m_err | ev;
      end
      default: begin
        m_phase = P_IDLE;
        m_col   = 0;
        m_err   = m_err | ev;
      end
    endcase
  endtask

  // Assert reset between edges (ps_valid left as driven) and confirm outputs
  // drop before the next rising edge.
  task automatic apply_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_cal",       32'(cal),       32'(0));
    check("rst_acc_clr",   32'(acc_clr),   32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_col",   32'(out_col),   32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_done",      32'(done),      32'(0));
`ifdef ACC_CTRL_ERR_EN
    check("rst_err",       32'(err),       32'(0));
`endif
    start     = 1'b0;
    ps_valid  = 1'b0;
    out_ready = 1'b0;
    m_phase      = P_IDLE;
    m_beats_left = 0;
    m_col        = 0;
    m_err        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // psv_mode: 0 always 1, 1 toggling, 2 random.
  // rdy_mode: 0 always 1, 1 stall 3 cycles at column 2, 2 random.
  task automatic run_job(input logic [TW-1:0] nt, input int psv_mode, input int rdy_mode,
                         input bit noise, input bit psv_on_start);
    int stall = 0;
    bit acc_pulsed = 1'b0;
    bit drn_pulsed = 1'b0;
    bit s, psv, rdy;
    int k;
    step(1'b1, nt, psv_on_start, 1'b1);
    for (k = 0; (k < 3000) && (m_phase != P_IDLE); k++) begin
      s = 1'b0;
      case (psv_mode)
        0:       psv = 1'b1;
        1:       psv = k[0];
        default: psv = 1'($urandom_range(0, 1));
      endcase
      case (rdy_mode)
        0: rdy = 1'b1;
        1: begin
          if ((m_phase == P_DRAIN) && (m_col == 2) && (stall < 3)) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (noise) begin
        if ((m_phase == P_ACCUM) && !acc_pulsed) begin
          s = 1'b1;
          acc_pulsed = 1'b1;
        end else if ((m_phase == P_DRAIN) && !drn_pulsed) begin
          s = 1'b1;
          drn_pulsed = 1'b1;
        end
      end
      step(s, TW'($urandom), psv, rdy);
    end
    if (m_phase != P_IDLE) check("job_timeout", 32'(m_phase), 32'(P_IDLE));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_tiles = '0;
    ps_valid  = 1'b0;
    out_ready = 1'b0;

    apply_reset();
    step(1'b0, '0, 1'b0, 1'b0);

    // T1: two tiles, beats held high (also high in CLEAR and DRAIN).
    run_job(TW'(2), 0, 0, 1'b0, 1'b1);
    // T2: num_tiles=0 treated as one tile, toggled beats.
    run_job(TW'(0), 1, 0, 1'b0, 1'b0);
    // T3: drain stalled three cycles at column 2.
    run_job(TW'(1), 2, 1, 1'b0, 1'b0);
    // T4: start pulsed during ACCUM and DRAIN; err must be set afterwards.
    run_job(TW'(2), 2, 2, 1'b1, 1'b0);
`ifdef ACC_CTRL_ERR_EN
    check("t4_err_sticky", 32'(err), 32'(1));
`endif
    // T5: reset after 5 beats of a 3-tile job, then a fresh 2-tile job.
    step(1'b1, TW'(3), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1, 1'b1);
    apply_reset();
    run_job(TW'(2), 2, 2, 1'b0, 1'b0);
    // T6: beats during CLEAR/DRAIN with random backpressure.
    run_job(TW'(1), 0, 2, 1'b0, 1'b0);
    run_job(TW'(255), 0, 0, 1'b0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 7) == 0,
             TW'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
